// File: rtl/tb_cmd_dispatch_if.sv
`timescale 1ns/1ps
// Handshake bundle between a command source, the dispatcher and its wait/set stages.
// master: command source and stage side; slave: the dispatcher.
interface tb_cmd_dispatch_if #(
    parameter int ARGS_NB = 5
);
    logic  i_cmd_valid;
    logic  o_cmd_ready;
    string i_cmd_args [ARGS_NB];
    logic  o_sel_wait;
    logic  o_sel_set;
    logic  o_args_valid;
    string o_args [ARGS_NB];
    logic  i_wait_done;
    logic  i_set_done;

    modport master (
        output i_cmd_valid, i_cmd_args, i_wait_done, i_set_done,
        input  o_cmd_ready, o_sel_wait, o_sel_set, o_args_valid, o_args
    );

    modport slave (
        input  i_cmd_valid, i_cmd_args, i_wait_done, i_set_done,
        output o_cmd_ready, o_sel_wait, o_sel_set, o_args_valid, o_args
    );
endinterface

// File: rtl/tb_cmd_dispatch.sv
`timescale 1ns/1ps
// Command dispatcher: queues token commands, decodes the opcode and issues each one to the wait or set stage.
// Define CMD_DISPATCH_WATCHDOG_EN to abandon a command whose done never arrives within WATCHDOG_CYCLES.
module tb_cmd_dispatch #(
    parameter int ARGS_NB         = 5,
    parameter int FIFO_DEPTH      = 4,
    parameter int WATCHDOG_CYCLES = 100000
) (
    input  logic             clk,
    input  logic             rst_n,
    tb_cmd_dispatch_if.slave bus,
    output logic             o_busy,
    output logic [31:0]      o_cmd_count,
    output logic [1:0]       o_err_code
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, DECODE, ISSUE, WAIT_DONE} state_t;

    state_t           state, state_nxt;
    string            mem [FIFO_DEPTH][ARGS_NB];
    string            hold [ARGS_NB];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fill;
    logic             ready_en, ready, full, empty, push, pop;
    logic             tgt_wait, tgt_wait_nxt;
    logic             cool, cool_nxt;
    logic             done_sel, cnt_inc, err_bad, err_wd;

    assign full     = (fill == (PTR_W+1)'(FIFO_DEPTH));
    assign empty    = (fill == '0);
    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign ready    = ready_en && (!full || pop);
    assign push     = bus.i_cmd_valid && ready;
    assign done_sel = tgt_wait ? bus.i_wait_done : bus.i_set_done;
    assign o_busy   = (state != IDLE) || !empty;
    assign bus.o_cmd_ready = ready;

`ifdef CMD_DISPATCH_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
    logic            wd_expire;

    assign wd_expire = (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wd_cnt <= '0;
        else if (state == WAIT_DONE)
            wd_cnt <= wd_cnt + 1'b1;
        else
            wd_cnt <= '0;
    end
`endif

    always_comb begin
        state_nxt        = state;
        tgt_wait_nxt     = tgt_wait;
        cool_nxt         = 1'b0;
        pop              = 1'b0;
        cnt_inc          = 1'b0;
        err_bad          = 1'b0;
        err_wd           = 1'b0;
        bus.o_args_valid = 1'b0;
        bus.o_sel_wait   = 1'b0;
        bus.o_sel_set    = 1'b0;
        case (state)
            IDLE: begin
                // cool holds off one IDLE cycle after a same-cycle done to keep strobes 4 apart
                if (!empty && !cool) begin
                    pop       = 1'b1;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                if (hold[0] == "WTR" || hold[0] == "WTF") begin
                    tgt_wait_nxt = 1'b1;
                    state_nxt    = ISSUE;
                end else if (hold[0] == "SET") begin
                    tgt_wait_nxt = 1'b0;
                    state_nxt    = ISSUE;
                end else begin
                    err_bad   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            ISSUE: begin
                bus.o_args_valid = 1'b1;
                bus.o_sel_wait   = tgt_wait;
                bus.o_sel_set    = !tgt_wait;
                if (done_sel) begin
                    cnt_inc   = 1'b1;
                    cool_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                bus.o_sel_wait = tgt_wait;
                bus.o_sel_set  = !tgt_wait;
                if (done_sel) begin
                    cnt_inc   = 1'b1;
                    state_nxt = IDLE;
                end
`ifdef CMD_DISPATCH_WATCHDOG_EN
                else if (wd_expire) begin
                    err_wd    = 1'b1;
                    state_nxt = IDLE;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            tgt_wait    <= 1'b0;
            cool        <= 1'b0;
            ready_en    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fill        <= '0;
            o_cmd_count <= '0;
            o_err_code  <= 2'b00;
        end else begin
            state    <= state_nxt;
            tgt_wait <= tgt_wait_nxt;
            cool     <= cool_nxt;
            ready_en <= 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fill <= fill + 1'b1;
            else if (pop && !push)
                fill <= fill - 1'b1;
            if (cnt_inc)
                o_cmd_count <= o_cmd_count + 1'b1;
            if (err_wd)
                o_err_code <= 2'b10;
            else if (err_bad)
                o_err_code <= 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            for (int i = 0; i < ARGS_NB; i++)
                mem[wr_ptr][i] <= bus.i_cmd_args[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARGS_NB; i++)
                hold[i] <= "";
        end else if (pop) begin
            for (int i = 0; i < ARGS_NB; i++)
                hold[i] <= mem[rd_ptr][i];
        end
    end

    always_comb begin
        for (int i = 0; i < ARGS_NB; i++)
            bus.o_args[i] = hold[i];
    end
endmodule

// File: tb/tb_tb_cmd_dispatch.sv
`timescale 1ns/1ps
// Bench for tb_cmd_dispatch: directed scenarios plus a randomized run checked against a queue-based model.
// Build with +define+CMD_DISPATCH_WATCHDOG_EN to exercise the watchdog expiry path.
module tb_tb_cmd_dispatch;
    localparam int ARGS_NB = 5;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        busy;
    logic [31:0] cmd_count;
    logic [1:0]  err_code;
    int          total = 0;
    int          bad   = 0;

    tb_cmd_dispatch_if #(.ARGS_NB(ARGS_NB)) bus ();

    tb_cmd_dispatch #(
        .ARGS_NB(ARGS_NB), .FIFO_DEPTH(4), .WATCHDOG_CYCLES(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .o_busy(busy), .o_cmd_count(cmd_count), .o_err_code(err_code)
    );

    always #5 clk = ~clk;

    // Reference model: expected issue records in push order, completions and sticky error.
    string      exp_q[$];
    string      got_q[$];
    int         exp_cnt = 0;
    logic [1:0] exp_err = 2'b00;
    string      ops [5] = '{"WTR", "WTF", "SET", "FOO", "NOP"};

    int strobes = 0, sel_w_cycles = 0, excl_viol = 0, gap_viol = 0;
    int cyc_n = 0, last_strobe = -100;
    int resp_delay = 0, rcnt = 0;
    bit resp_rand, resp_noise, resp_mute, pend, rtgt;
    int s0;

    function automatic string rec(input string tgt, input string a0, a1, a2, a3, a4);
        return $sformatf("%s:%s|%s|%s|%s|%s", tgt, a0, a1, a2, a3, a4);
    endfunction

    always @(negedge clk) begin
        cyc_n++;
        if (bus.o_sel_wait && bus.o_sel_set) excl_viol++;
        if (bus.o_sel_wait) sel_w_cycles++;
        if (bus.o_args_valid) begin
            strobes++;
            if (cyc_n - last_strobe < 4) gap_viol++;
            last_strobe = cyc_n;
            got_q.push_back(rec((bus.o_sel_wait && !bus.o_sel_set) ? "W" :
                                ((bus.o_sel_set && !bus.o_sel_wait) ? "S" : "?"),
                                bus.o_args[0], bus.o_args[1], bus.o_args[2],
                                bus.o_args[3], bus.o_args[4]));
        end
    end

    // Stage responder: answers each strobe on the selected done after a delay, optionally toggling the other done.
    always @(negedge clk) begin
        bus.i_wait_done = 1'b0;
        bus.i_set_done  = 1'b0;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (bus.o_args_valid && !resp_mute) begin
                pend = 1'b1;
                rtgt = bus.o_sel_wait;
                rcnt = resp_rand ? int'($urandom_range(0, 4)) : resp_delay;
            end
            if (pend) begin
                if (rcnt == 0) begin
                    if (rtgt) bus.i_wait_done = 1'b1;
                    else      bus.i_set_done  = 1'b1;
                    pend = 1'b0;
                end else begin
                    rcnt--;
                    if (resp_noise) begin
                        if (rtgt) bus.i_set_done  = 1'b1;
                        else      bus.i_wait_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic chk_s(input string tag, input string got, input string exp);
        total++;
        assert (got == exp) else begin
            bad++;
            $error("FAIL %s: observed=\"%s\" expected=\"%s\"", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push_cmd(input string t0, t1, t2, t3, t4);
        int n = 0;
        bus.i_cmd_args[0] = t0; bus.i_cmd_args[1] = t1; bus.i_cmd_args[2] = t2;
        bus.i_cmd_args[3] = t3; bus.i_cmd_args[4] = t4;
        bus.i_cmd_valid = 1'b1;
        while (bus.o_cmd_ready !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk_b("push_accept", n < 300, 1'b1);
        @(negedge clk);
        bus.i_cmd_valid = 1'b0;
        if (t0 == "WTR" || t0 == "WTF") begin
            exp_q.push_back(rec("W", t0, t1, t2, t3, t4));
            exp_cnt++;
        end else if (t0 == "SET") begin
            exp_q.push_back(rec("S", t0, t1, t2, t3, t4));
            exp_cnt++;
        end else begin
            exp_err = 2'b01;
        end
    endtask

    task automatic wait_strobe();
        int n = 0;
        while (bus.o_args_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk_b("strobe_seen", n < 200, 1'b1);
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy !== 1'b0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        chk_b("drain_idle", n < limit, 1'b1);
    endtask

    task automatic check_queue();
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk_s("issue_order", got_q.pop_front(), exp_q.pop_front());
        chk("extra_strobes", got_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        got_q.delete();
        exp_q.delete();
        exp_cnt = 0;
        exp_err = 2'b00;
    endtask

    initial begin
        bus.i_cmd_valid = 1'b0;
        for (int i = 0; i < ARGS_NB; i++) bus.i_cmd_args[i] = "";
        #2 rst_n = 1'b0;
        #1;
        chk_b("rst_ready", bus.o_cmd_ready, 1'b0);
        chk_b("rst_busy", busy, 1'b0);
        chk("rst_count", cmd_count, 0);
        chk("rst_err", {30'b0, err_code}, 0);
        chk_b("rst_sel_wait", bus.o_sel_wait, 1'b0);
        chk_b("rst_valid", bus.o_args_valid, 1'b0);
        chk_s("rst_args", bus.o_args[0], "");
        cyc(2);
        rst_n = 1'b1;
        #1 chk_b("ready_before_edge", bus.o_cmd_ready, 1'b0);
        @(negedge clk);
        chk_b("ready_after_edge", bus.o_cmd_ready, 1'b1);

        // WTR with done five cycles after the strobe
        resp_delay = 5;
        sel_w_cycles = 0;
        s0 = strobes;
        push_cmd("WTR", "SIG0", "100", "ns", "");
        chk_b("busy_after_push", busy, 1'b1);
        cyc(1);
        chk_b("no_strobe_decode", bus.o_args_valid, 1'b0);
        cyc(1);
        chk_b("strobe_latency", bus.o_args_valid, 1'b1);
        chk_b("strobe_sel_wait", bus.o_sel_wait, 1'b1);
        chk_s("strobe_arg1", bus.o_args[1], "SIG0");
        wait_idle(100);
        chk("wtr_strobes", strobes - s0, 1);
        chk("wtr_sel_cycles", sel_w_cycles, 6);
        chk("wtr_count", cmd_count, exp_cnt);
        check_queue();

        // SET completes only on set_done, wait_done toggles meanwhile
        resp_delay = 3;
        resp_noise = 1'b1;
        push_cmd("SET", "REG1", "7", "", "");
        cyc(2);
        chk_b("set_sel", bus.o_sel_set, 1'b1);
        cyc(2);
        chk("set_ignore_wait", cmd_count, exp_cnt - 1);
        chk_b("set_still_sel", bus.o_sel_set, 1'b1);
        wait_idle(100);
        chk("set_count", cmd_count, exp_cnt);
        resp_noise = 1'b0;

        // bad opcode dropped, next command issued
        resp_delay = 1;
        s0 = strobes;
        push_cmd("FOO", "X", "", "", "");
        push_cmd("SET", "A", "B", "C", "D");
        wait_idle(100);
        chk("bad_op_strobes", strobes - s0, 1);
        chk("bad_op_err", {30'b0, err_code}, {30'b0, exp_err});
        chk("bad_op_count", cmd_count, exp_cnt);
        check_queue();

        // fill the FIFO behind a long-running command
        resp_delay = 30;
        s0 = strobes;
        push_cmd("SET", "Q0", "", "", "");
        wait_strobe();
        push_cmd("WTR", "Q1", "", "", "");
        push_cmd("WTF", "Q2", "", "", "");
        push_cmd("SET", "Q3", "", "", "");
        push_cmd("WTR", "Q4", "", "", "");
        chk_b("full_not_ready", bus.o_cmd_ready, 1'b0);
        push_cmd("SET", "Q5", "", "", "");
        chk_b("full_after_swap", bus.o_cmd_ready, 1'b0);
        chk("fifo_one_issued", strobes - s0, 1);
        resp_delay = 1;
        wait_idle(400);
        chk("fifo_all_issued", strobes - s0, 6);
        chk("fifo_count", cmd_count, exp_cnt);
        check_queue();

        // reset while waiting with two queued commands
        resp_delay = 50;
        s0 = strobes;
        push_cmd("WTR", "Z0", "", "", "");
        wait_strobe();
        push_cmd("WTR", "Z1", "", "", "");
        push_cmd("SET", "Z2", "", "", "");
        cyc(3);
        check_queue();
        rst_n = 1'b0;
        #1;
        chk_b("mid_rst_sel", bus.o_sel_wait, 1'b0);
        chk_b("mid_rst_valid", bus.o_args_valid, 1'b0);
        chk_s("mid_rst_args", bus.o_args[0], "");
        chk("mid_rst_count", cmd_count, 0);
        chk("mid_rst_err", {30'b0, err_code}, 0);
        chk_b("mid_rst_busy", busy, 1'b0);
        chk_b("mid_rst_ready", bus.o_cmd_ready, 1'b0);
        cyc(2);
        rst_n = 1'b1;
        exp_q.delete();
        exp_cnt = 0;
        exp_err = 2'b00;
        cyc(30);
        chk("post_rst_strobes", strobes - s0, 1);
        chk_b("post_rst_busy", busy, 1'b0);

        // done never arrives
        resp_mute = 1'b1;
        push_cmd("WTR", "WD", "", "", "");
        wait_strobe();
`ifdef CMD_DISPATCH_WATCHDOG_EN
        cyc(20);
        chk("wd_err_before", {30'b0, err_code}, 0);
        chk_b("wd_sel_before", bus.o_sel_wait, 1'b1);
        cyc(1);
        chk("wd_err_after", {30'b0, err_code}, 2);
        chk_b("wd_sel_after", bus.o_sel_wait, 1'b0);
        chk("wd_count", cmd_count, 0);
        chk_b("wd_busy", busy, 1'b0);
`else
        cyc(40);
        chk_b("nowd_sel", bus.o_sel_wait, 1'b1);
        chk("nowd_err", {30'b0, err_code}, 0);
        chk_b("nowd_busy", busy, 1'b1);
        chk("nowd_count", cmd_count, 0);
`endif
        resp_mute = 1'b0;
        do_reset();

        // randomized commands against the model
        resp_rand  = 1'b1;
        resp_noise = 1'b1;
        for (int n = 0; n < 40; n++) begin
            push_cmd(ops[$urandom_range(0, 4)], $sformatf("R%0d", n),
                     $sformatf("%0d", $urandom_range(0, 999)), "ns", "");
            cyc(int'($urandom_range(0, 3)));
        end
        wait_idle(500);
        chk("rand_count", cmd_count, exp_cnt);
        chk("rand_err", {30'b0, err_code}, {30'b0, exp_err});
        check_queue();
        chk("sel_exclusive", excl_viol, 0);
        chk("strobe_gap", gap_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
